// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state codes and
// parameter defaults used by the top module and the shifter.
package serial_pattern_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam int WIDTH_DEFAULT      = 8;
  localparam int GAP_CYCLES_DEFAULT = 2;

endpackage : serial_pattern_pkg

// File: rtl/serial_pattern_tx_shifter.sv
// MSB-first shift register for the serial pattern transmitter; load takes
// priority over shift so a word reload on the last bit starts cleanly.
module tx_shifter
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule : tx_shifter

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit word MSB first rep+1 times,
// separated by GAP_CYCLES idle-low cycles, with a one-cycle done pulse.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       rep,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] shadow_data;
  logic [1:0]       rep_left;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] load_data;
  logic             msb;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    load_data = shadow_data;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
          load      = 1'b1;
          load_data = data;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (bit_cnt == BIT_LAST) begin
          if (rep_left != 2'd0) begin
            // Reload the captured word for the next repeat.
            load      = 1'b1;
            state_nxt = (GAP_CYCLES == 0) ? ST_SHIFT : ST_GAP;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = ST_SHIFT;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Abort overrides everything, including a coincident start in IDLE.
    if (abort) begin
      state_nxt = ST_IDLE;
      load      = 1'b0;
      shift     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      shadow_data <= '0;
      rep_left    <= 2'd0;
      bit_cnt     <= '0;
      gap_cnt     <= 4'd0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        rep_left <= 2'd0;
        bit_cnt  <= '0;
        gap_cnt  <= 4'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              shadow_data <= data;
              rep_left    <= rep;
              bit_cnt     <= '0;
              gap_cnt     <= 4'd0;
            end
          end
          ST_SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (rep_left != 2'd0) rep_left <= rep_left - 2'd1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_GAP: begin
            gap_cnt <= (gap_cnt == GAP_LAST) ? 4'd0 : gap_cnt + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  tx_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .din     (load_data),
    .msb     (msb)
  );

  // Outputs decode from registered state, so reset clears them immediately.
  assign out  = (state == ST_SHIFT) & msb;
  assign busy = (state == ST_SHIFT) || (state == ST_GAP);
  assign done = (state == ST_DONE);

endmodule : serial_pattern_tx
